// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I MEM stage: loads, word stores, read-modify-write SB/SH, MEM/WB register.
// Optional MEM_STAGE_FAULT_EN: range and funct3 checks that reject the access and raise wb_fault.
module mem_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        wb_fault
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] MERGE = 1'b1;

`ifdef MEM_STAGE_FAULT_EN
  localparam bit FaultEn = 1'b1;
`else
  localparam bit FaultEn = 1'b0;
`endif

  logic [0:0]  state_q, state_d;
  logic [31:0] merge_q;

  logic        is_mem;
  logic        f3_illegal;
  logic        size_byte, size_half;
  logic [2:0]  access_bytes;
  logic [32:0] end_addr;
  logic        fault;
  logic        sub_store, word_store;
  logic [31:0] merge_d;
  logic [31:0] load_data;
  logic        accept;

  assign is_mem     = in_load | in_store;
  // Illegal funct3 falls back to a word-sized access.
  assign f3_illegal = (in_funct3[1:0] == 2'b11) || (in_funct3 == 3'b110);
  assign size_byte  = (in_funct3[1:0] == 2'b00) && !f3_illegal;
  assign size_half  = (in_funct3[1:0] == 2'b01) && !f3_illegal;

  always_comb begin
    access_bytes = 3'd4;
    if (size_byte)      access_bytes = 3'd1;
    else if (size_half) access_bytes = 3'd2;
  end

  assign end_addr   = {1'b0, in_addr} + {30'b0, access_bytes};
  assign fault      = FaultEn && is_mem && (f3_illegal || (end_addr > 33'(MEM_BYTES)));
  assign sub_store  = in_store && !fault && (size_byte || size_half);
  assign word_store = in_store && !fault && !(size_byte || size_half);

  assign merge_d = size_byte ? {mem_rdata[31:8], in_wdata[7:0]}
                             : {mem_rdata[31:16], in_wdata[15:0]};

  always_comb begin
    load_data = mem_rdata;
    if (size_byte)
      load_data = {{24{~in_funct3[2] & mem_rdata[7]}}, mem_rdata[7:0]};
    else if (size_half)
      load_data = {{16{~in_funct3[2] & mem_rdata[15]}}, mem_rdata[15:0]};
  end

  assign mem_addr = in_addr;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b1;
    mem_write = 1'b0;
    mem_wdata = in_wdata;
    case (state_q)
      RUN: begin
        if (in_valid && sub_store) begin
          in_ready = 1'b0;
          state_d  = MERGE;
        end else if (in_valid && word_store) begin
          mem_write = 1'b1;
        end
      end
      MERGE: begin
        mem_write = 1'b1;
        mem_wdata = merge_q;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      merge_q <= 32'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN && in_valid && sub_store)
        merge_q <= merge_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_rd        <= 5'b0;
      wb_reg_write <= 1'b0;
      wb_data      <= 32'b0;
      wb_fault     <= 1'b0;
    end else if (accept) begin
      wb_valid <= 1'b1;
      wb_rd    <= in_rd;
      wb_fault <= fault;
      if (fault || in_store) begin
        wb_reg_write <= 1'b0;
        wb_data      <= 32'b0;
      end else begin
        wb_reg_write <= in_reg_write;
        wb_data      <= in_load ? load_data : in_addr;
      end
    end else begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage with a byte-array memory model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_load, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write;
  logic        wb_valid, wb_reg_write, wb_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:1023];
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = 32'b0;
  logic [31:0] pre_data = 32'b0;

  always #5 clk = ~clk;

  mem_stage #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .wb_fault(wb_fault)
  );

  assign mem_rdata = {mem[10'(mem_addr[9:0] + 10'd3)], mem[10'(mem_addr[9:0] + 10'd2)],
                      mem[10'(mem_addr[9:0] + 10'd1)], mem[mem_addr[9:0]]};

  always @(posedge clk) begin
    if (pre_we) begin
      for (int k = 0; k < 4; k++) mem[10'(pre_addr[9:0] + 10'(k))] <= pre_data[8*k +: 8];
    end else if (mem_write) begin
      for (int k = 0; k < 4; k++) mem[10'(mem_addr[9:0] + 10'(k))] <= mem_wdata[8*k +: 8];
    end
  end

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {mem[10'(a[9:0] + 10'd3)], mem[10'(a[9:0] + 10'd2)], mem[10'(a[9:0] + 10'd1)], mem[a[9:0]]};
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic rw);
    in_valid = v; in_load = ld; in_store = st; in_funct3 = f3;
    in_addr = a; in_wdata = wd; in_rd = rd; in_reg_write = rw;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_data !== 32'h0) begin failures++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
    checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd); end
    checks++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL reset_wb_reg_write got=%b exp=0", wb_reg_write); end
    checks++; if (wb_fault !== 1'b0) begin failures++; $display("FAIL reset_wb_fault got=%b exp=0", wb_fault); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_word;
    preload(32'h10, 32'h8899AABB);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lw_in_ready got=%b exp=1", in_ready); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL lw_mem_write got=%b exp=0", mem_write); end
    checks++; if (mem_addr !== 32'h10) begin failures++; $display("FAIL lw_mem_addr got=%h exp=00000010", mem_addr); end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL lw_wb_valid got=%b exp=1", wb_valid); end
    checks++; if (wb_data !== 32'h8899AABB) begin failures++; $display("FAIL lw_wb_data got=%h exp=8899aabb", wb_data); end
    checks++; if (wb_rd !== 5'd5) begin failures++; $display("FAIL lw_wb_rd got=%0d exp=5", wb_rd); end
    checks++; if (wb_reg_write !== 1'b1) begin failures++; $display("FAIL lw_wb_reg_write got=%b exp=1", wb_reg_write); end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL idle_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_data !== 32'h8899AABB) begin failures++; $display("FAIL idle_wb_data_hold got=%h exp=8899aabb", wb_data); end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3  [0:6];
    logic [31:0] adr [0:6];
    logic [31:0] exp [0:6];
    f3[0] = 3'b000; adr[0] = 32'h20; exp[0] = 32'h00000044;
    f3[1] = 3'b001; adr[1] = 32'h20; exp[1] = 32'h00003344;
    f3[2] = 3'b100; adr[2] = 32'h21; exp[2] = 32'h00000033;
    f3[3] = 3'b100; adr[3] = 32'h23; exp[3] = 32'h00000080;
    f3[4] = 3'b000; adr[4] = 32'h23; exp[4] = 32'hFFFFFF80;
    f3[5] = 3'b001; adr[5] = 32'h22; exp[5] = 32'hFFFF8000;
    f3[6] = 3'b101; adr[6] = 32'h22; exp[6] = 32'h00008000;
    preload(32'h20, 32'h11223344);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) preload(32'h20, 32'h80003344);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, f3[i], adr[i], 32'h0, 5'd9, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== exp[i]) begin
        failures++;
        $display("FAIL load_ext[%0d] f3=%b addr=%h got valid=%b data=%h exp valid=1 data=%h",
                 i, f3[i], adr[i], wb_valid, wb_data, exp[i]);
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic test_store_byte;
    preload(32'h40, 32'h11223344);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h40, 32'h123456AA, 5'd3, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL sb_c1_in_ready got=%b exp=0", in_ready); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL sb_c1_mem_write got=%b exp=0", mem_write); end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL sb_c1_wb_valid got=%b exp=0", wb_valid); end
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sb_c2_in_ready got=%b exp=1", in_ready); end
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL sb_c2_mem_write got=%b exp=1", mem_write); end
    checks++; if (mem_wdata !== 32'h112233AA) begin failures++; $display("FAIL sb_c2_mem_wdata got=%h exp=112233aa", mem_wdata); end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_data !== 32'h0)
      begin failures++; $display("FAIL sb_wb got valid=%b rw=%b data=%h exp valid=1 rw=0 data=0", wb_valid, wb_reg_write, wb_data); end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd4, 1'b1);
    @(posedge clk); #1;
    checks++; if (wb_data !== 32'h112233AA) begin failures++; $display("FAIL sb_then_lw got=%h exp=112233aa", wb_data); end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    preload(32'h50, 32'h01020304);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h50, 32'hCAFEF00D, 5'd0, 1'b0);
    #1;
    checks++; if (mem_write !== 1'b1 || mem_wdata !== 32'hCAFEF00D || in_ready !== 1'b1)
      begin failures++; $display("FAIL sw_write got we=%b wdata=%h rdy=%b exp we=1 wdata=cafef00d rdy=1", mem_write, mem_wdata, in_ready); end
    @(posedge clk); #1 pulses += int'(wb_valid);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h50, 32'h1234BEEF, 5'd0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0 || mem_write !== 1'b0)
      begin failures++; $display("FAIL sh_stall got rdy=%b we=%b exp rdy=0 we=0", in_ready, mem_write); end
    @(posedge clk); #1 pulses += int'(wb_valid);
    @(negedge clk); #1;
    checks++; if (mem_write !== 1'b1 || mem_wdata !== 32'hCAFEBEEF)
      begin failures++; $display("FAIL sh_merge got we=%b wdata=%h exp we=1 wdata=cafebeef", mem_write, mem_wdata); end
    @(posedge clk); #1 pulses += int'(wb_valid);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    @(posedge clk); #1 pulses += int'(wb_valid);
    checks++; if (pulses != 2) begin failures++; $display("FAIL b2b_wb_pulses got=%0d exp=2", pulses); end
    checks++; if (rd_word(32'h50) !== 32'hCAFEBEEF) begin failures++; $display("FAIL b2b_mem_word got=%h exp=cafebeef", rd_word(32'h50)); end
  endtask

  task automatic test_reset_merge;
    preload(32'h60, 32'h55667788);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h60, 32'h00000099, 5'd0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rstm_mem_write got=%b exp=0", mem_write); end
    checks++; if (wb_valid !== 1'b0 || wb_data !== 32'h0 || wb_rd !== 5'd0 || wb_reg_write !== 1'b0 || wb_fault !== 1'b0)
      begin failures++; $display("FAIL rstm_wb got v=%b d=%h rd=%0d rw=%b f=%b exp all 0", wb_valid, wb_data, wb_rd, wb_reg_write, wb_fault); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstm_state_run got in_ready=%b exp=0", in_ready); end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    checks++; if (rd_word(32'h60) !== 32'h55667788) begin failures++; $display("FAIL rstm_mem_word got=%h exp=55667788", rd_word(32'h60)); end
    @(posedge clk); #1;
  endtask

`ifdef MEM_STAGE_FAULT_EN
  task automatic test_fault;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h3FE, 32'h0, 5'd7, 1'b1);
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b1 || wb_fault !== 1'b1 || wb_data !== 32'h0 || wb_reg_write !== 1'b0)
      begin failures++; $display("FAIL fault_lw got v=%b f=%b d=%h rw=%b exp v=1 f=1 d=0 rw=0", wb_valid, wb_fault, wb_data, wb_reg_write); end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h3FE, 32'hDEADBEEF, 5'd0, 1'b0);
    #1;
    checks++; if (mem_write !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL fault_sw got we=%b rdy=%b exp we=0 rdy=1", mem_write, in_ready); end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h3FF, 32'h0000BEEF, 5'd0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL fault_sh got rdy=%b we=%b exp rdy=1 we=0", in_ready, mem_write); end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 5'd7, 1'b1);
    @(posedge clk); #1;
    checks++; if (wb_fault !== 1'b1) begin failures++; $display("FAIL fault_funct3 got=%b exp=1", wb_fault); end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd7, 1'b1);
    @(posedge clk); #1;
    checks++; if (wb_fault !== 1'b0 || wb_data !== 32'h8899AABB) begin failures++; $display("FAIL fault_clear got f=%b d=%h exp f=0 d=8899aabb", wb_fault, wb_data); end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask
`else
  task automatic test_no_fault;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h3FE, 32'h0, 5'd7, 1'b1);
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b1 || wb_fault !== 1'b0) begin failures++; $display("FAIL nofault_lw got v=%b f=%b exp v=1 f=0", wb_valid, wb_fault); end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 5'd7, 1'b1);
    @(posedge clk); #1;
    checks++; if (wb_fault !== 1'b0 || wb_data !== 32'h8899AABB) begin failures++; $display("FAIL nofault_funct3_word got f=%b d=%h exp f=0 d=8899aabb", wb_fault, wb_data); end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store_byte();
    test_back_to_back();
    test_reset_merge();
`ifdef MEM_STAGE_FAULT_EN
    test_fault();
`else
    test_no_fault();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage of the 5-stage RV32I core. It sits between the EX/MEM pipeline register and the byte-addressed data memory (combinational 32-bit little-endian read, synchronous full-word write), and produces the MEM/WB register. Loads use 1 cycle; `SB`/`SH` need 2 cycles, because the memory writes only whole words. Those 2 cycles are a read-modify-write sequence that stalls upstream for one cycle. Loads are sign/zero-extended here; non-memory instructions pass through.

## Interface
- `MEM_BYTES`, default 1024: data-memory size in bytes; used for the range check.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: EX/MEM slot holds an instruction.
- `in_ready` out 1: stage accepts the slot this cycle.
- `in_load`, `in_store` in 1 each: memory op type. Both 0 means pass-through.
- `in_funct3` in 3: access size/sign.
- `in_addr` in 32: byte address, which is the ALU result.
- `in_wdata` in 32: store data (rs2).
- `in_rd` in 5: destination register.
- `in_reg_write` in 1: writeback enable.
- `mem_addr` out 32: address to memory.
- `mem_wdata` out 32: word to memory.
- `mem_write` out 1: memory write strobe, sampled on `clk`.
- `mem_rdata` in 32: memory read data, combinational from `mem_addr`.
- `wb_valid`, `wb_rd`, `wb_reg_write` out 1/5/1: MEM/WB register.
- `wb_data` out 32: extended load data or pass-through ALU result.
- `wb_fault` out 1: access was rejected.

## Operation
- FSM states: `RUN` and `MERGE`. Reset state is `RUN`.
- `in_funct3` decoding:
  - 000 = byte, signed.
  - 001 = half, signed.
  - 010 = word.
  - 100 = byte, unsigned (load only).
  - 101 = half, unsigned (load only).
- `mem_addr` = `in_addr` in both states. Memory returns bytes `[a+3..a]`; the addressed data is always in the low bits of `mem_rdata`.
- **RUN, pass-through** (`in_valid`, not load/store): `in_ready` = 1; `wb_data` ← `in_addr`.
- **RUN, load**: `in_ready` = 1; `wb_data` ← `mem_rdata` extended per `funct3`.
  - Byte: bits `[7:0]`, sign- or zero-extended from bit 7.
  - Half: bits `[15:0]`, extended from bit 15.
  - Word: all 32 bits.
- **RUN, `SW`**: `in_ready` = 1; `mem_write` = 1 and `mem_wdata` = `in_wdata` in the same cycle.
- **RUN, `SB`/`SH`**:
  - `in_ready` = 0 and `mem_write` = 0.
  - Latch the merged word in a 32-bit merge register: `{mem_rdata[31:8], in_wdata[7:0]}` for SB, `{mem_rdata[31:16], in_wdata[15:0]}` for SH.
  - Go to `MERGE`.
- **MERGE**: `mem_write` = 1, `mem_wdata` = merge register, `in_ready` = 1; return to `RUN`.
- Stores: `wb_reg_write` ← 0, `wb_data` ← 0.
- Upstream rule: while `in_valid` = 1 and `in_ready` = 0, every `in_*` signal holds stable.
- Funct3 values 011/110/111 on a memory op are illegal; behaviour is set by Configuration.
- No back-pressure from WB.

## Timing
- MEM/WB outputs are registered and update on the edge where `in_valid & in_ready`. On any other edge `wb_valid` ← 0 and the other `wb_*` outputs hold.
- Latency: 1 cycle for load, `SW` and pass-through; 2 cycles for `SB`/`SH`. Throughput is 1/cycle except the `SB`/`SH` stall.
- `mem_write`, `mem_wdata` and `in_ready` are combinational from state and inputs. Memory commits the write on the edge that ends the cycle.
- Reset values: state `RUN`, merge register 0, `wb_valid` 0, `wb_rd` 0, `wb_data` 0, `wb_reg_write` 0, `wb_fault` 0.
- Reset asserted during `MERGE`: no write is committed; the pending store is dropped.
- Back-to-back `SB` then load to the same word: the load executes in the cycle after `MERGE` and reads the merged word.

## Configuration
- `MEM_STAGE_FAULT_EN` defined:
  - Faulting accesses:
    - `in_addr + size > MEM_BYTES`, where size is 1, 2 or 4.
    - An illegal `funct3` on a memory op.
  - For a faulting access: no memory write, no `MERGE` entry, `in_ready` = 1, `wb_fault` ← 1, `wb_reg_write` ← 0, `wb_data` ← 0.
- `MEM_STAGE_FAULT_EN` undefined:
  - No range check; `wb_fault` is constant 0.
  - Illegal `funct3` is treated as a word access.

## Test plan
- After reset, `LW` at 0x10 with memory word 0x8899AABB: `wb_valid` = 1 and `wb_data` = 0x8899AABB one cycle later; `mem_write` is never high.
- Memory word at 0x20 is 0x11223344:
  - `LB` at 0x20: `wb_data` = 0x00000044.
  - `LBU` at 0x23 with byte 0x80: `wb_data` = 0x00000080.
  - `LH` at 0x22 with half 0x8000: `wb_data` = 0xFFFF8000.
- `SB` 0xAA at 0x40 over 0x11223344:
  - `in_ready` = 0 in cycle 1.
  - `mem_write` = 1 with `mem_wdata` = 0x112233AA in cycle 2.
  - A following `LW` at 0x40 returns 0x112233AA.
- `SW` then `SH` 0xBEEF at 0x50, back-to-back: the `SW` writes in 1 cycle; the `SH` stalls 1 cycle and writes `{old[31:16], 0xBEEF}`; exactly one `wb_valid` pulse per instruction.
- Pulse `rst_n` low during `MERGE` of an `SB` at 0x60: the memory word is unchanged, all `wb_*` outputs read 0, and the FSM is in `RUN` after release.
- With `MEM_STAGE_FAULT_EN`:
  - `LW` at 0x3FE: `wb_fault` = 1, `wb_data` = 0, `wb_reg_write` = 0.
  - `SW` at 0x3FE: `mem_write` stays 0.
